// File: rtl/sqrt_pkg.sv
// +------------------------------------------------------------------+
// | sqrt_pkg: shared state encoding and default sizing for the       |
// | square-root scheduler.                          Revision: 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;
  localparam int DEF_IDW   = 3;

endpackage

`default_nettype wire

// File: rtl/sqrt_iter.sv
// +------------------------------------------------------------------+
// | sqrt_iter: restoring bit-pair integer square root, one pair per  |
// | cycle, WIDTH/2 cycles per result.               Revision: 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   radicand,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic               exact
);

  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;
  localparam int CW = $clog2(HW + 1);

  logic [RW-1:0]    rem_q, rem_d;
  logic [HW-1:0]    root_q, root_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [HW-1:0]    src_root;
  logic [WIDTH-1:0] src_rad;
  logic [RW-1:0]    shifted, trial, diff;
  logic             fits;

  // The start cycle already performs the first iteration straight from the
  // input radicand, so the last pair is consumed WIDTH/2-1 edges later.
  // Before any shift the remainder is below 2^HW, so the shifted value
  // always fits in RW bits.
  always_comb begin
    rem_d    = rem_q;
    root_d   = root_q;
    rad_d    = rad_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    src_root = start ? '0 : root_q;
    src_rad  = start ? radicand : rad_q;
    shifted  = start ? {{(RW-2){1'b0}}, radicand[WIDTH-1 -: 2]}
                     : {rem_q[RW-3:0], rad_q[WIDTH-1 -: 2]};
    trial    = {src_root, 2'b01};
    fits     = (shifted >= trial);
    diff     = shifted - trial;
    if (start || busy_q) begin
      rem_d  = fits ? diff : shifted;
      root_d = {src_root[HW-2:0], fits};
      rad_d  = {src_rad[WIDTH-3:0], 2'b00};
    end
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(HW - 1);
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      root_q <= '0;
      rad_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      root_q <= root_d;
      rad_q  <= rad_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done  = done_q;
  assign root  = root_q;
  assign exact = (rem_q == '0);

endmodule

`default_nettype wire

// File: rtl/sqrt_scheduler.sv
// +------------------------------------------------------------------+
// | sqrt_scheduler: round-robin sharing of one iterative square-root |
// | engine among NREQ requesters.                   Revision: 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module sqrt_scheduler
  import sqrt_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = DEF_IDW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_radicand,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_root,
  output logic                  resp_exact
);

  localparam int HW = WIDTH / 2;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   pend_id_q, pend_id_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_root_q, resp_root_d;
  logic             resp_exact_q, resp_exact_d;

  logic             found;
  logic [IDW-1:0]   gnt_idx;
  int               idx;
  logic             start;
  logic             eng_done;
  logic [HW-1:0]    eng_root;
  logic             eng_exact;

  // Scan from the farthest candidate back to ptr so the nearest valid wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pend_id_d    = pend_id_q;
    resp_id_d    = resp_id_q;
    resp_root_d  = resp_root_q;
    resp_exact_d = resp_exact_q;
    start        = 1'b0;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = NREQ'(1) << gnt_idx;
          start     = 1'b1;
          pend_id_d = gnt_idx;
          ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (eng_done) begin
          resp_id_d    = pend_id_q;
          resp_root_d  = {{(WIDTH - HW){1'b0}}, eng_root};
          resp_exact_d = eng_exact;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      pend_id_q    <= '0;
      resp_id_q    <= '0;
      resp_root_q  <= '0;
      resp_exact_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pend_id_q    <= pend_id_d;
      resp_id_q    <= resp_id_d;
      resp_root_q  <= resp_root_d;
      resp_exact_q <= resp_exact_d;
    end
  end

  sqrt_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .radicand (req_radicand[gnt_idx*WIDTH +: WIDTH]),
    .done     (eng_done),
    .root     (eng_root),
    .exact    (eng_exact)
  );

  assign resp_valid = (state_q == DONE);
  assign resp_id    = resp_id_q;
  assign resp_root  = resp_root_q;
  assign resp_exact = resp_exact_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_scheduler.sv
// +------------------------------------------------------------------+
// | tb_sqrt_scheduler: directed self-checking bench for the shared   |
// | square-root scheduler.                          Revision: 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sqrt_scheduler;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
  localparam int IDW   = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_radicand;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_root;
  logic                  resp_exact;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  sqrt_scheduler #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_radicand (req_radicand),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_root    (resp_root),
    .resp_exact   (resp_exact)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for grant and result, then complete the handshake.
  task automatic serve(input int r, input logic [7:0] rad, output int lat,
                       output logic [2:0] id, output logic [7:0] root,
                       output logic exact);
    int n;
    req_radicand[r*WIDTH +: WIDTH] = rad;
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid[r] = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    id    = resp_id;
    root  = resp_root;
    exact = resp_exact;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_radicand = '0;
    resp_ready = 1'b0;
    tick(); tick(); tick();
    total_cnt++;
    if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
    else pass_cnt++;
    total_cnt++;
    if ({resp_id, resp_root, resp_exact} !== 12'd0)
      $display("FAIL reset_resp_fields: got id=%0d root=%0d exact=%b expected 0/0/0",
               resp_id, resp_root, resp_exact);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exact();
    int lat; logic [2:0] id; logic [7:0] root; logic exact;
    serve(0, 8'd16, lat, id, root, exact);
    total_cnt++;
    if (lat !== 4) $display("FAIL exact_latency: got %0d expected 4", lat);
    else pass_cnt++;
    total_cnt++;
    if ({id, root, exact} !== {3'd0, 8'd4, 1'b1})
      $display("FAIL exact_16: got id=%0d root=%0d exact=%b expected 0/4/1", id, root, exact);
    else pass_cnt++;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL exact_handshake: got resp_valid=%b expected 0", resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_nonsquare();
    logic [7:0] rads [3]  = '{8'd17, 8'd255, 8'd0};
    logic [7:0] roots [3] = '{8'd4, 8'd15, 8'd0};
    logic       exs [3]   = '{1'b0, 1'b0, 1'b1};
    int lat; logic [2:0] id; logic [7:0] root; logic exact;
    for (int i = 0; i < 3; i++) begin
      serve(1, rads[i], lat, id, root, exact);
      total_cnt++;
      if ({lat, id, root, exact} !== {32'd4, 3'd1, roots[i], exs[i]})
        $display("FAIL nonsquare_%0d: got lat=%0d id=%0d root=%0d exact=%b expected 4/1/%0d/%b",
                 rads[i], lat, id, root, exact, roots[i], exs[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    logic [1:0] gnts [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [2:0] ids [4]   = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [7:0] roots [4] = '{8'd2, 8'd3, 8'd2, 8'd3};
    int n;
    req_radicand = {8'd9, 8'd4};
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin
        tick();
        n++;
      end
      total_cnt++;
      if (req_ready !== gnts[i])
        $display("FAIL contention_grant_%0d: got %b expected %b", i, req_ready, gnts[i]);
      else pass_cnt++;
      tick();
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      total_cnt++;
      if ({resp_id, resp_root} !== {ids[i], roots[i]})
        $display("FAIL contention_resp_%0d: got id=%0d root=%0d expected %0d/%0d",
                 i, resp_id, resp_root, ids[i], roots[i]);
      else pass_cnt++;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    int n; int highs;
    req_radicand[7:0] = 8'd100;
    req_valid[0] = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL bp_grant: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 4) $display("FAIL bp_latency: got %0d expected 4", n);
    else pass_cnt++;
    req_radicand[15:8] = 8'd50;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++;
      if ({resp_valid, resp_id, resp_root, resp_exact, req_ready} !== {1'b1, 3'd0, 8'd10, 1'b1, 2'b00})
        $display("FAIL bp_hold_%0d: got v=%b id=%0d root=%0d exact=%b rdy=%b expected 1/0/10/1/00",
                 c, resp_valid, resp_id, resp_root, resp_exact, req_ready);
      else pass_cnt++;
    end
    req_valid[1] = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    highs = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid === 1'b1) highs++;
      tick();
    end
    total_cnt++;
    if (highs !== 0) $display("FAIL bp_single_handshake: got %0d extra valid cycles expected 0", highs);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    int highs; int lat; logic [2:0] id; logic [7:0] root; logic exact;
    req_radicand[7:0] = 8'd200;
    req_valid[0] = 1'b1;
    #1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({req_ready, resp_valid, resp_id, resp_root, resp_exact} !== 15'd0)
      $display("FAIL rst_busy_outputs: got rdy=%b v=%b id=%0d root=%0d exact=%b expected all 0",
               req_ready, resp_valid, resp_id, resp_root, resp_exact);
    else pass_cnt++;
    highs = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid === 1'b1) highs++;
      tick();
    end
    total_cnt++;
    if (highs !== 0) $display("FAIL rst_busy_no_resp: got %0d valid cycles expected 0", highs);
    else pass_cnt++;
    req_radicand = {8'd9, 8'd9};
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL rst_busy_ptr: got %b expected 01", req_ready);
    else pass_cnt++;
    req_valid[1] = 1'b0;
    serve(0, 8'd9, lat, id, root, exact);
    total_cnt++;
    if ({lat, id, root, exact} !== {32'd4, 3'd0, 8'd3, 1'b1})
      $display("FAIL rst_busy_fresh: got lat=%0d id=%0d root=%0d exact=%b expected 4/0/3/1",
               lat, id, root, exact);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    int lat; logic [2:0] id; logic [7:0] root; logic exact;
    int m; logic mx;
    for (int x = 0; x < 256; x++) begin
      m = 0;
      while ((m + 1) * (m + 1) <= x) m++;
      mx = (m * m == x);
      serve(0, 8'(x), lat, id, root, exact);
      total_cnt++;
      if (lat !== 4 || id !== 3'd0 || root !== 8'(m) || exact !== mx)
        $display("FAIL sweep_%0d: got lat=%0d id=%0d root=%0d exact=%b expected 4/0/%0d/%b",
                 x, lat, id, root, exact, m, mx);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_nonsquare();
    test_contention();
    test_backpressure();
    test_reset_mid_busy();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

`default_nettype wire
